// File: rtl/command_arb_pkg.sv
// rtl/command_arb_pkg.sv - shared helpers for the round-robin command arbiter
`ifndef COMMAND_ARB_PKG_SV
`define COMMAND_ARB_PKG_SV

package command_arb_pkg;

  // Command MSBs kept above the inserted source tag.
  localparam int TAG_MSBS = 2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // LSB position of the source tag inside the tagged output word.
  function automatic int tag_pos(input int cmd_w);
    return cmd_w - TAG_MSBS;
  endfunction

endpackage

`define COMMAND_ARB_CHECK_SRC_W(nsrc, srcw) \
  if ((srcw) != command_arb_pkg::clog2(nsrc)) begin : g_src_w_check \
    $error("SRC_W must equal clog2(NUM_SRC)"); \
  end

`endif

// File: rtl/command_fifo_sync.sv
// rtl/command_fifo_sync.sv - per-source show-ahead command FIFO
module command_fifo_sync
  import command_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = clog2(DEPTH);

  if ((1 << AW) != DEPTH || DEPTH < 2) begin : g_depth_check
    $error("DEPTH must be a power of two, at least 2");
  end

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rd_en = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: rtl/command_arbiter_rr.sv
// rtl/command_arbiter_rr.sv - buffered round-robin merger of tagged configuration commands
module command_arbiter_rr
  import command_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int CMD_W      = 64,
  parameter int SRC_W      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_SRC*CMD_W-1:0] iv_command,
  input  logic [NUM_SRC-1:0]       iv_command_wr,
  output logic [CMD_W+SRC_W-1:0]   ov_command,
  output logic                     o_command_wr,
  output logic [NUM_SRC-1:0]       ov_fifo_full,
  output logic [NUM_SRC*CNT_W-1:0] ov_drop_cnt
);

  `COMMAND_ARB_CHECK_SRC_W(NUM_SRC, SRC_W)

  localparam int               TAG_POS  = tag_pos(CMD_W);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_SRC - 1);

  logic [NUM_SRC-1:0]     fifo_empty;
  logic [NUM_SRC-1:0]     fifo_full;
  logic [NUM_SRC-1:0]     pop;
  logic [CMD_W-1:0]       fifo_dout [NUM_SRC];
  logic [SRC_W-1:0]       rr_ptr;
  logic [SRC_W-1:0]       grant_idx;
  logic [SRC_W-1:0]       cand;
  logic                   grant_vld;
  int                     scan_idx;
  logic [CMD_W-1:0]       grant_cmd;
  logic [CMD_W+SRC_W-1:0] tagged_cmd;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [CNT_W-1:0] drop_cnt;
    logic             drop_evt;

    command_fifo_sync #(
      .DATA_W (CMD_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (iv_command_wr[s]),
      .data    (iv_command[s*CMD_W +: CMD_W]),
      .pop     (pop[s]),
      .dout    (fifo_dout[s]),
      .empty   (fifo_empty[s]),
      .full    (fifo_full[s])
    );

    assign drop_evt = iv_command_wr[s] && fifo_full[s] && !pop[s];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        drop_cnt <= '0;
      end else if (drop_evt && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end

    assign ov_drop_cnt[s*CNT_W +: CNT_W] = drop_cnt;
  end

  assign ov_fifo_full = fifo_full;

  // First non-empty source at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= NUM_SRC) scan_idx = scan_idx - NUM_SRC;
      cand = SRC_W'(scan_idx);
      if (!grant_vld && !fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    pop[grant_idx] = grant_vld;
  end

  assign grant_cmd  = fifo_dout[grant_idx];
  assign tagged_cmd = {grant_cmd[CMD_W-1 -: TAG_MSBS], grant_idx, grant_cmd[TAG_POS-1:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr       <= '0;
      ov_command   <= '0;
      o_command_wr <= 1'b0;
    end else begin
      o_command_wr <= grant_vld;
      ov_command   <= grant_vld ? tagged_cmd : '0;
      if (grant_vld) rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + SRC_W'(1);
    end
  end

endmodule

// File: tb/tb_command_arbiter_rr.sv
// tb/tb_command_arbiter_rr.sv - directed self-checking bench for command_arbiter_rr
module tb_command_arbiter_rr;

  localparam int NS = 4;
  localparam int CW = 64;
  localparam int OW = 66;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NS*CW-1:0] cmd_in;
  logic [NS-1:0]    cmd_wr;
  logic [OW-1:0]    out_cmd;
  logic             out_wr;
  logic [NS-1:0]    full;
  logic [NS*16-1:0] drop;
  logic [OW-1:0]    out_cmd2;
  logic             out_wr2;
  logic [NS-1:0]    full2;
  logic [NS*2-1:0]  drop2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  command_arbiter_rr u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .iv_command    (cmd_in),
    .iv_command_wr (cmd_wr),
    .ov_command    (out_cmd),
    .o_command_wr  (out_wr),
    .ov_fifo_full  (full),
    .ov_drop_cnt   (drop)
  );

  command_arbiter_rr #(.CNT_W(2)) u_sat (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .iv_command    (cmd_in),
    .iv_command_wr (cmd_wr),
    .ov_command    (out_cmd2),
    .o_command_wr  (out_wr2),
    .ov_fifo_full  (full2),
    .ov_drop_cnt   (drop2)
  );

  typedef struct {
    logic [3:0]  wr;
    logic [63:0] base;
    logic        exp_wr;
    logic [1:0]  exp_tag;
    logic [63:0] exp_base;
  } vec_t;

  vec_t vecs [14];

  logic [63:0] mq [4][4];
  int          mcnt [4];
  int          mdrop [4];
  int          mptr;

  function automatic logic [OW-1:0] tag_cmd(input logic [63:0] c, input logic [1:0] t);
    return {c[63:62], t, c[61:0]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [63:0] v);
    cmd_in[s*CW +: CW] = v;
  endtask

  task automatic do_reset;
    cmd_wr = '0;
    cmd_in = '0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_reset;
    mptr = 0;
    for (int s = 0; s < 4; s++) begin
      mcnt[s]  = 0;
      mdrop[s] = 0;
    end
  endtask

  task automatic model_cycle(input logic [3:0] wr, input int c);
    logic [63:0]   pl;
    logic          gv;
    int            g;
    int            k;
    logic [OW-1:0] eo;
    logic [3:0]    ef;
    gv = 1'b0;
    g  = 0;
    for (int i = 0; i < 4; i++) begin
      k = (mptr + i) % 4;
      if (!gv && mcnt[k] > 0) begin
        gv = 1'b1;
        g  = k;
      end
    end
    eo = gv ? tag_cmd(mq[g][0], 2'(g)) : '0;
    if (gv) begin
      for (int j = 0; j < 3; j++) mq[g][j] = mq[g][j+1];
      mcnt[g]--;
      mptr = (g + 1) % 4;
    end
    for (int s = 0; s < 4; s++) begin
      pl = 64'h5000_0000_0000_0000 | (64'(c) << 8) | 64'(s);
      set_src(s, pl);
      if (wr[s]) begin
        if (mcnt[s] < 4) begin
          mq[s][mcnt[s]] = pl;
          mcnt[s]++;
        end else begin
          mdrop[s]++;
        end
      end
    end
    cmd_wr = wr;
    tick;
    for (int s = 0; s < 4; s++) ef[s] = (mcnt[s] == 4);
    chk($sformatf("ovf_cmd_c%0d", c), out_cmd, eo);
    chk($sformatf("ovf_wr_c%0d", c), out_wr, gv);
    chk($sformatf("ovf_full_c%0d", c), full, ef);
    chk($sformatf("ovf_drop1_c%0d", c), drop[16 +: 16], mdrop[1]);
  endtask

  initial begin
    logic [OW-1:0] exp;
    logic [1:0]    exp_tag;

    vecs[0]  = '{4'b1111, 64'hC000_0000_0000_0A00, 1'b0, 2'd0, 64'h0};
    vecs[1]  = '{4'b0000, 64'h0, 1'b1, 2'd0, 64'hC000_0000_0000_0A00};
    vecs[2]  = '{4'b0000, 64'h0, 1'b1, 2'd1, 64'hC000_0000_0000_0A00};
    vecs[3]  = '{4'b0000, 64'h0, 1'b1, 2'd2, 64'hC000_0000_0000_0A00};
    vecs[4]  = '{4'b0000, 64'h0, 1'b1, 2'd3, 64'hC000_0000_0000_0A00};
    vecs[5]  = '{4'b0000, 64'h0, 1'b0, 2'd0, 64'h0};
    vecs[6]  = '{4'b1000, 64'h4000_0000_0000_0B00, 1'b0, 2'd0, 64'h0};
    vecs[7]  = '{4'b0001, 64'h8000_0000_0000_0C00, 1'b1, 2'd3, 64'h4000_0000_0000_0B00};
    vecs[8]  = '{4'b0000, 64'h0, 1'b1, 2'd0, 64'h8000_0000_0000_0C00};
    vecs[9]  = '{4'b0000, 64'h0, 1'b0, 2'd0, 64'h0};
    vecs[10] = '{4'b0101, 64'h0000_0000_0000_0D00, 1'b0, 2'd0, 64'h0};
    vecs[11] = '{4'b0000, 64'h0, 1'b1, 2'd2, 64'h0000_0000_0000_0D00};
    vecs[12] = '{4'b0000, 64'h0, 1'b1, 2'd0, 64'h0000_0000_0000_0D00};
    vecs[13] = '{4'b0000, 64'h0, 1'b0, 2'd0, 64'h0};

    cmd_wr = '0;
    cmd_in = '0;
    rst_n  = 1'b0;
    #12;
    chk("rst_cmd", out_cmd, '0);
    chk("rst_wr", out_wr, 1'b0);
    chk("rst_full", full, '0);
    chk("rst_drop", drop, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single source, top bits 2'b10 must survive tag insertion.
    cmd_wr = 4'b0100;
    set_src(2, 64'h8000_0000_0000_0001);
    tick;
    cmd_wr = '0;
    chk("single_k", out_wr, 1'b0);
    tick;
    chk("single_wr", out_wr, 1'b1);
    chk("single_cmd", out_cmd, 66'h2_8000_0000_0000_0001);
    tick;
    chk("single_idle", out_wr, 1'b0);

    do_reset;
    for (int r = 0; r < 14; r++) begin
      cmd_wr = vecs[r].wr;
      for (int s = 0; s < 4; s++) set_src(s, vecs[r].base | 64'(s));
      tick;
      exp = vecs[r].exp_wr ? tag_cmd(vecs[r].exp_base | 64'(vecs[r].exp_tag), vecs[r].exp_tag) : '0;
      chk($sformatf("vec%0d_cmd", r), out_cmd, exp);
      chk($sformatf("vec%0d_wr", r), out_wr, vecs[r].exp_wr);
      chk($sformatf("vec%0d_full", r), full, '0);
    end
    cmd_wr = '0;

    // Sources 0 and 3 strobing every cycle must alternate with no gap.
    do_reset;
    for (int c = 0; c < 20; c++) begin
      cmd_wr = 4'b1001;
      set_src(0, 64'(c));
      set_src(3, 64'(c) | 64'h100);
      tick;
      if (c == 0) begin
        chk("fair_first", out_wr, 1'b0);
      end else begin
        exp_tag = (c % 2 == 1) ? 2'd0 : 2'd3;
        chk($sformatf("fair_c%0d", c), {out_wr, out_cmd[63:62]}, {1'b1, exp_tag});
      end
    end
    cmd_wr = '0;

    // Source 1 overflow against busy neighbours; drain shows the coinciding push survived.
    do_reset;
    model_reset;
    for (int c = 0; c < 7; c++) model_cycle(4'b1111, c);
    chk("ovf_full1", full[1], 1'b1);
    chk("ovf_drop1", drop[16 +: 16], 16'd1);
    for (int c = 7; c < 25; c++) model_cycle(4'b0000, c);
    chk("ovf_drained", out_wr, 1'b0);

    // 2-bit counters in u_sat: five drops each on sources 0 and 1.
    do_reset;
    for (int c = 0; c < 12; c++) begin
      cmd_wr = 4'b1111;
      for (int s = 0; s < 4; s++) set_src(s, 64'(c * 4 + s));
      tick;
      if (c == 7) chk("sat_src0_mid", drop2[1:0], 2'd2);
      if (c == 9) chk("sat_src1_four", drop2[3:2], 2'd3);
    end
    cmd_wr = '0;
    chk("sat_src0", drop2[1:0], 2'd3);
    chk("sat_src1", drop2[3:2], 2'd3);

    // Reset while every FIFO holds two entries.
    do_reset;
    cmd_wr = 4'b1111;
    for (int s = 0; s < 4; s++) set_src(s, 64'hA0 + 64'(s));
    tick;
    tick;
    cmd_wr = 4'b0011;
    tick;
    cmd_wr = '0;
    chk("mid_pre_wr", out_wr, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", out_wr, 1'b0);
    chk("mid_rst_cmd", out_cmd, '0);
    chk("mid_rst_full", full, '0);
    chk("mid_rst_drop", drop, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk($sformatf("mid_stale_c%0d", c), out_wr, 1'b0);
    end
    cmd_wr = 4'b1001;
    set_src(0, 64'h0000_0000_0000_0E00);
    set_src(3, 64'h0000_0000_0000_0E03);
    tick;
    cmd_wr = '0;
    tick;
    chk("mid_ptr_first", out_cmd, tag_cmd(64'h0000_0000_0000_0E00, 2'd0));
    tick;
    chk("mid_ptr_second", out_cmd, tag_cmd(64'h0000_0000_0000_0E03, 2'd3));
    tick;
    chk("mid_final_idle", out_wr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
